// File: rtl/mole_hit_scorer_if.sv
// Bus between the game logic and mole_hit_scorer: lit moles, player switches and
// game controls in; score, hit/miss pulses and lockout status out.
interface mole_hit_scorer_if #(
    parameter int unsigned SCORE_MAX = 999
) ();
    localparam int unsigned N_MOLES = 18;
    localparam int unsigned SCORE_W = $clog2(SCORE_MAX + 1);

    logic [N_MOLES-1:0] moles;
    logic [N_MOLES-1:0] switches;
    logic               game_en;
    logic [1:0]         level;
    logic [SCORE_W-1:0] score;
    logic [N_MOLES-1:0] hit_mask;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               locked;

    modport master (
        output moles, switches, game_en, level,
        input  score, hit_mask, hit_pulse, miss_pulse, locked
    );

    modport slave (
        input  moles, switches, game_en, level,
        output score, hit_mask, hit_pulse, miss_pulse, locked
    );
endinterface

// File: rtl/mole_hit_scorer.sv
// Whack-a-mole scorer: synchronises player switches, scores toggles on lit moles and
// locks the player out after a miss. Optional macro MISS_PENALTY_EN deducts 1 per miss cycle.
module mole_hit_scorer #(
    parameter int unsigned SCORE_MAX      = 999,
    parameter int unsigned LOCKOUT_CYCLES = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    mole_hit_scorer_if.slave bus
);
    localparam int unsigned N_MOLES = 18;
    localparam int unsigned SCORE_W = $clog2(SCORE_MAX + 1);
    localparam int unsigned SUM_W   = SCORE_W + 8;
    localparam int unsigned PC_W    = 5;
    localparam int unsigned PTS_W   = 7;
    localparam int unsigned CNT_W   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
    logic [SCORE_W-1:0] score_q, score_nxt;
    logic [N_MOLES-1:0] hit_mask_q, hit_mask_nxt;
    logic               hit_pulse_q, hit_pulse_nxt;
    logic               miss_pulse_q, miss_pulse_nxt;
    logic               locked_q, locked_nxt;

    logic [N_MOLES-1:0] sync1, sync2, hist;
    logic [N_MOLES-1:0] whack, hits, misses;
    logic [PC_W-1:0]    hit_cnt;
    logic [PTS_W-1:0]   points;
    logic [SUM_W-1:0]   sum;

    // Two-flop synchroniser followed by the previous-cycle history used for toggle detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= bus.switches;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign whack  = sync2 ^ hist;
    assign hits   = whack & bus.moles;
    assign misses = whack & ~bus.moles;

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < N_MOLES; i++) begin
            hit_cnt = hit_cnt + PC_W'(hits[i]);
        end
    end

    assign points = PTS_W'(hit_cnt) * (PTS_W'(bus.level) + PTS_W'(1));

    // Hit points first, then the optional miss penalty (floored at 0), then the ceiling
    always_comb begin
        sum = SUM_W'(score_q) + SUM_W'(points);
`ifdef MISS_PENALTY_EN
        if ((|misses) && (sum != '0)) begin
            sum = sum - SUM_W'(1);
        end
`endif
        if (sum > SUM_W'(SCORE_MAX)) begin
            sum = SUM_W'(SCORE_MAX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lock_cnt     <= '0;
            score_q      <= '0;
            hit_mask_q   <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state        <= state_nxt;
            lock_cnt     <= lock_cnt_nxt;
            score_q      <= score_nxt;
            hit_mask_q   <= hit_mask_nxt;
            hit_pulse_q  <= hit_pulse_nxt;
            miss_pulse_q <= miss_pulse_nxt;
            locked_q     <= locked_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        lock_cnt_nxt   = '0;
        score_nxt      = score_q;
        hit_mask_nxt   = '0;
        hit_pulse_nxt  = 1'b0;
        miss_pulse_nxt = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = ACTIVE;
            end
            ACTIVE: begin
                hit_mask_nxt   = hits;
                hit_pulse_nxt  = |hits;
                miss_pulse_nxt = |misses;
                score_nxt      = SCORE_W'(sum);
                if (|misses) begin
                    state_nxt = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (lock_cnt == CNT_W'(LOCKOUT_CYCLES - 1)) begin
                    state_nxt = ACTIVE;
                end else begin
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Disabling the game overrides everything; the score is kept
        if (!bus.game_en) begin
            state_nxt      = IDLE;
            lock_cnt_nxt   = '0;
            score_nxt      = score_q;
            hit_mask_nxt   = '0;
            hit_pulse_nxt  = 1'b0;
            miss_pulse_nxt = 1'b0;
        end

        locked_nxt = (state_nxt == LOCKOUT);
    end

    assign bus.score      = score_q;
    assign bus.hit_mask   = hit_mask_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;
    assign bus.locked     = locked_q;
endmodule

// File: tb/tb_mole_hit_scorer.sv
// Self-checking bench for mole_hit_scorer: directed scenarios plus randomized play
// checked against a cycle-level behavioural model of the game rules.
`timescale 1ns/1ps
module tb_mole_hit_scorer;
    localparam int unsigned LOCK  = 10;
    localparam int unsigned MAX_A = 999;
    localparam int unsigned MAX_B = 5;
    localparam int unsigned SW_A  = $clog2(MAX_A + 1);
    localparam int unsigned SW_B  = $clog2(MAX_B + 1);
`ifdef MISS_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    localparam int S_IDLE = 0;
    localparam int S_ACT  = 1;
    localparam int S_LOCK = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] moles;
    logic [17:0] switches;
    logic        game_en;
    logic [1:0]  level;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mole_hit_scorer_if #(.SCORE_MAX(MAX_A)) bus_a ();
    mole_hit_scorer_if #(.SCORE_MAX(MAX_B)) bus_b ();

    assign bus_a.moles    = moles;
    assign bus_a.switches = switches;
    assign bus_a.game_en  = game_en;
    assign bus_a.level    = level;
    assign bus_b.moles    = moles;
    assign bus_b.switches = switches;
    assign bus_b.game_en  = game_en;
    assign bus_b.level    = level;

    mole_hit_scorer #(.SCORE_MAX(MAX_A), .LOCKOUT_CYCLES(LOCK)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    mole_hit_scorer #(.SCORE_MAX(MAX_B), .LOCKOUT_CYCLES(LOCK)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    // Reference model: switch history in clock order, game state as plain integers
    logic [17:0] m_hist [3] = '{18'h0, 18'h0, 18'h0};
    logic [17:0] m_w;
    logic [17:0] m_mask = '0;
    logic        m_hit  = 1'b0;
    logic        m_miss = 1'b0;
    int          m_state = S_IDLE;
    int          m_left  = 0;
    int          m_score [2] = '{0, 0};
    int          m_pts;
    int          m_s;

    function automatic int cap_of(int k);
        return (k == 0) ? int'(MAX_A) : int'(MAX_B);
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_hist  = '{18'h0, 18'h0, 18'h0};
            m_mask  = '0;
            m_hit   = 1'b0;
            m_miss  = 1'b0;
            m_state = S_IDLE;
            m_left  = 0;
            m_score = '{0, 0};
        end else begin
            m_w       = m_hist[1] ^ m_hist[2];
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = switches;
            m_mask    = '0;
            m_hit     = 1'b0;
            m_miss    = 1'b0;
            if (!game_en) begin
                m_state = S_IDLE;
            end else if (m_state == S_IDLE) begin
                m_state = S_ACT;
            end else if (m_state == S_LOCK) begin
                m_left = m_left - 1;
                if (m_left == 0) m_state = S_ACT;
            end else begin
                m_mask = m_w & moles;
                m_hit  = |m_mask;
                m_miss = |(m_w & ~moles);
                m_pts  = $countones(m_mask) * (int'(level) + 1);
                for (int k = 0; k < 2; k++) begin
                    m_s = m_score[k] + m_pts - ((PEN && m_miss) ? 1 : 0);
                    if (m_s < 0) m_s = 0;
                    if (m_s > cap_of(k)) m_s = cap_of(k);
                    m_score[k] = m_s;
                end
                if (m_miss) begin
                    m_state = S_LOCK;
                    m_left  = int'(LOCK);
                end
            end
        end
    end

    task automatic do_reset();
        switches = '0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (bus_a.score !== '0) begin n_bad++; $display("FAIL reset_score got=%0d exp=0", bus_a.score); end
        n_cmp++; if (bus_a.hit_mask !== '0) begin n_bad++; $display("FAIL reset_mask got=%h exp=0", bus_a.hit_mask); end
        n_cmp++; if ({bus_a.hit_pulse, bus_a.miss_pulse, bus_a.locked} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=000", {bus_a.hit_pulse, bus_a.miss_pulse, bus_a.locked}); end
        n_cmp++; if (bus_b.score !== '0) begin n_bad++; $display("FAIL reset_score_b got=%0d exp=0", bus_b.score); end
    endtask

    task automatic test_single_hit();
        int np = 0;
        logic [17:0] seen = '0;
        do_reset();
        game_en = 1'b1; level = 2'd0; moles = 18'h8;
        repeat (2) @(negedge clk);
        switches = switches ^ 18'h8;
        repeat (8) begin
            @(negedge clk);
            if (bus_a.hit_pulse) begin np++; seen = bus_a.hit_mask; end
        end
        n_cmp++; if (np != 1) begin n_bad++; $display("FAIL s1_pulses got=%0d exp=1", np); end
        n_cmp++; if (seen !== 18'h8) begin n_bad++; $display("FAIL s1_mask got=%h exp=00008", seen); end
        n_cmp++; if (bus_a.score !== SW_A'(1)) begin n_bad++; $display("FAIL s1_score got=%0d exp=1", bus_a.score); end
    endtask

    task automatic test_multi_hit();
        int np = 0;
        logic [17:0] seen = '0;
        level = 2'd3; moles = 18'h21;
        @(negedge clk);
        switches = switches ^ 18'h21;
        repeat (8) begin
            @(negedge clk);
            if (bus_a.hit_pulse) begin np++; seen = bus_a.hit_mask; end
        end
        n_cmp++; if (np != 1) begin n_bad++; $display("FAIL s2_pulses got=%0d exp=1", np); end
        n_cmp++; if (seen !== 18'h21) begin n_bad++; $display("FAIL s2_mask got=%h exp=00021", seen); end
        n_cmp++; if (bus_a.score !== SW_A'(9)) begin n_bad++; $display("FAIL s2_score got=%0d exp=9", bus_a.score); end
        n_cmp++; if (bus_b.score !== SW_B'(5)) begin n_bad++; $display("FAIL s2_score_sat got=%0d exp=5", bus_b.score); end
    endtask

    task automatic test_lockout();
        int nm = 0, nl = 0, nh = 0;
        bit poked = 1'b0;
        int exp_s = PEN ? 8 : 9;
        level = 2'd0;
        @(negedge clk);
        switches = switches ^ 18'h100;
        repeat (25) begin
            @(negedge clk);
            if (bus_a.miss_pulse) nm++;
            if (bus_a.hit_pulse) nh++;
            if (bus_a.locked) begin
                nl++;
                if (!poked) begin switches = switches ^ 18'h1; poked = 1'b1; end
            end
        end
        n_cmp++; if (nm != 1) begin n_bad++; $display("FAIL s3_miss_pulses got=%0d exp=1", nm); end
        n_cmp++; if (nl != int'(LOCK)) begin n_bad++; $display("FAIL s3_locked_cycles got=%0d exp=%0d", nl, LOCK); end
        n_cmp++; if (nh != 0) begin n_bad++; $display("FAIL s3_hits_in_lock got=%0d exp=0", nh); end
        n_cmp++; if (bus_a.score !== SW_A'(exp_s)) begin n_bad++; $display("FAIL s3_score got=%0d exp=%0d", bus_a.score, exp_s); end
        n_cmp++; if (bus_a.locked !== 1'b0) begin n_bad++; $display("FAIL s3_unlock got=%b exp=0", bus_a.locked); end
    endtask

    task automatic test_saturation();
        do_reset();
        game_en = 1'b1; level = 2'd0; moles = 18'h3FFFF;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            switches = switches ^ 18'h4;
            repeat (4) @(negedge clk);
        end
        n_cmp++; if (bus_b.score !== SW_B'(4)) begin n_bad++; $display("FAIL s4_pre got=%0d exp=4", bus_b.score); end
        level = 2'd1;
        switches = switches ^ 18'h4;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus_b.score !== SW_B'(5)) begin n_bad++; $display("FAIL s4_sat got=%0d exp=5", bus_b.score); end
        n_cmp++; if (bus_a.score !== SW_A'(6)) begin n_bad++; $display("FAIL s4_nosat got=%0d exp=6", bus_a.score); end
    endtask

    task automatic test_penalty();
        int nm = 0;
        int exp_s = PEN ? 3 : 4;
        do_reset();
        game_en = 1'b1; level = 2'd0; moles = 18'h1;
        repeat (2) @(negedge clk);
        switches = switches ^ 18'h2;
        repeat (6) begin @(negedge clk); if (bus_a.miss_pulse) nm++; end
        n_cmp++; if (nm != 1) begin n_bad++; $display("FAIL s5_miss got=%0d exp=1", nm); end
        n_cmp++; if (bus_a.score !== '0) begin n_bad++; $display("FAIL s5_floor got=%0d exp=0", bus_a.score); end
        repeat (12) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            switches = switches ^ 18'h1;
            repeat (4) @(negedge clk);
        end
        n_cmp++; if (bus_a.score !== SW_A'(3)) begin n_bad++; $display("FAIL s5_pre got=%0d exp=3", bus_a.score); end
        switches = switches ^ 18'h3;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus_a.score !== SW_A'(exp_s)) begin n_bad++; $display("FAIL s5_hit_miss got=%0d exp=%0d", bus_a.score, exp_s); end
        n_cmp++; if (bus_a.locked !== 1'b1) begin n_bad++; $display("FAIL s5_locked got=%b exp=1", bus_a.locked); end
    endtask

    task automatic test_reset_abort();
        int nh = 0;
        do_reset();
        game_en = 1'b1; level = 2'd0; moles = 18'h1FFFF;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            switches = switches ^ 18'h1;
            repeat (4) @(negedge clk);
        end
        n_cmp++; if (bus_a.score !== SW_A'(7)) begin n_bad++; $display("FAIL s6_pre got=%0d exp=7", bus_a.score); end
        switches = switches ^ 18'h20000;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus_a.locked !== 1'b1) begin n_bad++; $display("FAIL s6_locked got=%b exp=1", bus_a.locked); end
        switches = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus_a.score !== '0) begin n_bad++; $display("FAIL s6_async_score got=%0d exp=0", bus_a.score); end
        n_cmp++; if (bus_a.locked !== 1'b0) begin n_bad++; $display("FAIL s6_async_locked got=%b exp=0", bus_a.locked); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            switches = switches ^ 18'h2;
            repeat (4) @(negedge clk);
        end
        game_en = 1'b0;
        repeat (3) @(negedge clk);
        switches = switches ^ 18'h2;
        repeat (6) begin @(negedge clk); if (bus_a.hit_pulse) nh++; end
        n_cmp++; if (nh != 0) begin n_bad++; $display("FAIL s6_disabled_hits got=%0d exp=0", nh); end
        n_cmp++; if (bus_a.score !== SW_A'(2)) begin n_bad++; $display("FAIL s6_hold got=%0d exp=2", bus_a.score); end
    endtask

    task automatic test_random();
        do_reset();
        game_en = 1'b1; level = 2'd0; moles = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_cmp++; if (bus_a.score !== SW_A'(m_score[0])) begin n_bad++; $display("FAIL rnd_score_a cyc=%0d got=%0d exp=%0d", c, bus_a.score, m_score[0]); end
            n_cmp++; if (bus_b.score !== SW_B'(m_score[1])) begin n_bad++; $display("FAIL rnd_score_b cyc=%0d got=%0d exp=%0d", c, bus_b.score, m_score[1]); end
            n_cmp++; if (bus_a.hit_mask !== m_mask) begin n_bad++; $display("FAIL rnd_mask cyc=%0d got=%h exp=%h", c, bus_a.hit_mask, m_mask); end
            n_cmp++; if ({bus_a.hit_pulse, bus_a.miss_pulse} !== {m_hit, m_miss}) begin
                n_bad++; $display("FAIL rnd_pulses cyc=%0d got=%b exp=%b", c, {bus_a.hit_pulse, bus_a.miss_pulse}, {m_hit, m_miss}); end
            n_cmp++; if (bus_a.locked !== (m_state == S_LOCK)) begin n_bad++; $display("FAIL rnd_locked cyc=%0d got=%b exp=%b", c, bus_a.locked, m_state == S_LOCK); end
            moles = 18'($urandom());
            if ($urandom_range(0, 3) == 0) switches = switches ^ (18'h1 << $urandom_range(0, 17));
            if ($urandom_range(0, 15) == 0) switches = switches ^ (18'h1 << $urandom_range(0, 17));
            if ($urandom_range(0, 31) == 0) level = 2'($urandom_range(0, 3));
            if (game_en && $urandom_range(0, 199) == 0) game_en = 1'b0;
            else if (!game_en && $urandom_range(0, 7) == 0) game_en = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; moles = '0; switches = '0; game_en = 1'b0; level = 2'd0;
        test_reset();
        reset = 1'b0;
        test_single_hit();
        test_multi_hit();
        test_lockout();
        test_saturation();
        test_penalty();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
